// File: rtl/word_tokenizer.sv
// Splits a character stream into whitespace-delimited words and holds each word for a
// valid/ready consumer. Define WORD_TOKENIZER_BACKSPACE_EN to treat 0x08/0x7F as edit characters.
module word_tokenizer #(
   parameter  int WIDTH      = 32,
   localparam int WIDTH_BITS = $clog2(WIDTH) + 1,
   localparam int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_valid,
   output logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_word [WIDTH-1:0],
   output logic [WIDTH_BITS-1:0] o_len,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_ovf,
   output logic                  o_eol
);

   localparam int IDX_BITS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      HOLD    = 2'd2
   } state_t;

   state_t state, state_next;

   logic is_delim, is_eol, is_edit;
   logic wr_en, drop, bs_en, clr, eol_set;
   logic [WIDTH_BITS-1:0] len_m1;
   logic [IDX_BITS-1:0]   wr_idx, bs_idx;

   assign is_eol   = (i_data == 8'h0D) || (i_data == 8'h0A);
   assign is_delim = is_eol || (i_data == 8'h20) || (i_data == 8'h09);

`ifdef WORD_TOKENIZER_BACKSPACE_EN
   assign is_edit = (i_data == 8'h08) || (i_data == 8'h7F);
`else
   assign is_edit = 1'b0;
`endif

   // Indices are only used when the length is in range, so truncation is safe.
   assign len_m1 = o_len - 1'b1;
   assign wr_idx = o_len[IDX_BITS-1:0];
   assign bs_idx = len_m1[IDX_BITS-1:0];

   // Handshake flags come straight from the state register: no input-to-output paths.
   assign o_ready = (state != HOLD);
   assign o_valid = (state == HOLD);

   // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_next;
   end

   // NOTE: every output of this block gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_next = state;
      wr_en      = 1'b0;
      drop       = 1'b0;
      bs_en      = 1'b0;
      clr        = 1'b0;
      eol_set    = 1'b0;
      case (state)
         IDLE: begin
            if (i_valid && !is_delim && !is_edit) begin
               wr_en      = 1'b1;
               state_next = COLLECT;
            end
         end
         COLLECT: begin
            if (i_valid) begin
               if (is_edit) begin
                  bs_en = (o_len != '0);
               end else if (is_delim) begin
                  if (o_len != '0) begin
                     state_next = HOLD;
                     eol_set    = is_eol;
                  end else begin
                     // Word fully erased: drop any sticky overflow and emit nothing.
                     clr        = 1'b1;
                     state_next = IDLE;
                  end
               end else if (o_len < WIDTH_BITS'(WIDTH)) begin
                  wr_en = 1'b1;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         HOLD: begin
            if (i_ready) begin
               clr        = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: the word buffer is reset because unused entries are visible outputs that must read 0x00.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < WIDTH; i++) o_word[i] <= '0;
         o_len <= '0;
         o_ovf <= 1'b0;
         o_eol <= 1'b0;
      end else if (clr) begin
         for (int i = 0; i < WIDTH; i++) o_word[i] <= '0;
         o_len <= '0;
         o_ovf <= 1'b0;
         o_eol <= 1'b0;
      end else begin
         if (wr_en) begin
            o_word[wr_idx] <= i_data;
            o_len          <= o_len + 1'b1;
         end
         if (bs_en) begin
            o_word[bs_idx] <= '0;
            o_len          <= len_m1;
         end
         if (drop)    o_ovf <= 1'b1;
         if (eol_set) o_eol <= 1'b1;
      end
   end

endmodule

// File: tb/tb_word_tokenizer.sv
// Directed self-checking bench for word_tokenizer; a monitor records every word the
// consumer takes so the main sequence can compare against hand-computed words.
module tb_word_tokenizer;

   localparam int WIDTH = 32;
   localparam int WB    = $clog2(WIDTH) + 1;

   logic         i_clk = 1'b0;
   logic         i_rst_n;
   logic [7:0]   i_data;
   logic         i_valid;
   logic         o_ready;
   logic [7:0]   o_word [WIDTH-1:0];
   logic [WB-1:0] o_len;
   logic         o_valid;
   logic         i_ready;
   logic         o_ovf;
   logic         o_eol;

   int total = 0;
   int bad   = 0;

   word_tokenizer #(.WIDTH(WIDTH)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_data  (i_data),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .o_word  (o_word),
      .o_len   (o_len),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_ovf   (o_ovf),
      .o_eol   (o_eol)
   );

   always #5 i_clk = ~i_clk;

   // Captured words: one entry per word handed to the consumer.
   int         word_cnt = 0;
   int         valid_cycles = 0;
   logic [7:0] cap_word [16][WIDTH];
   int         cap_len  [16];
   logic       cap_ovf  [16];
   logic       cap_eol  [16];

   initial begin
      forever begin
         @(negedge i_clk);
         #1;
         if (o_valid) valid_cycles++;
         if (o_valid && i_ready && word_cnt < 16) begin
            for (int i = 0; i < WIDTH; i++) cap_word[word_cnt][i] = o_word[i];
            cap_len[word_cnt] = int'(o_len);
            cap_ovf[word_cnt] = o_ovf;
            cap_eol[word_cnt] = o_eol;
            word_cnt++;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Present one character from a negedge and return at the negedge after it is accepted.
   task automatic send(input logic [7:0] c);
      int n = 0;
      i_data  = c;
      i_valid = 1'b1;
      while (!o_ready && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      if (n >= 50) check("send_timeout", 32'(n), 32'd0);
      @(negedge i_clk);
      i_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   int base;
   int vbase;

   initial begin
      i_rst_n = 1'b0;
      i_data  = 8'h00;
      i_valid = 1'b0;
      i_ready = 1'b1;
      #12;
      check("rst_len",   32'(o_len),     32'd0);
      check("rst_valid", 32'(o_valid),   32'd0);
      check("rst_ready", 32'(o_ready),   32'd1);
      check("rst_ovf",   32'(o_ovf),     32'd0);
      check("rst_eol",   32'(o_eol),     32'd0);
      check("rst_word0", 32'(o_word[0]), 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // Basic word with one-cycle HOLD
      base = word_cnt;
      send_str("0x1F ");
      check("basic_valid", 32'(o_valid),   32'd1);
      check("basic_ready", 32'(o_ready),   32'd0);
      check("basic_len",   32'(o_len),     32'd4);
      check("basic_w0",    32'(o_word[0]), 32'h30);
      check("basic_w1",    32'(o_word[1]), 32'h78);
      check("basic_w2",    32'(o_word[2]), 32'h31);
      check("basic_w3",    32'(o_word[3]), 32'h46);
      check("basic_w4",    32'(o_word[4]), 32'h00);
      check("basic_ovf",   32'(o_ovf),     32'd0);
      check("basic_eol",   32'(o_eol),     32'd0);
      @(negedge i_clk);
      check("basic_ready_back", 32'(o_ready),   32'd1);
      check("basic_valid_drop", 32'(o_valid),   32'd0);
      check("basic_cleared",    32'(o_word[0]), 32'd0);
      check("basic_count",      32'(word_cnt - base), 32'd1);

      // Empty words and end of line
      base = word_cnt;
      send_str("  DUP\t\tSWAP\n");
      repeat (3) @(negedge i_clk);
      check("eol_count", 32'(word_cnt - base), 32'd2);
      check("dup_len",   32'(cap_len[base]), 32'd3);
      check("dup_w0",    32'(cap_word[base][0]), 32'h44);
      check("dup_w2",    32'(cap_word[base][2]), 32'h50);
      check("dup_w3",    32'(cap_word[base][3]), 32'h00);
      check("dup_eol",   32'(cap_eol[base]), 32'd0);
      check("swap_len",  32'(cap_len[base+1]), 32'd4);
      check("swap_w0",   32'(cap_word[base+1][0]), 32'h53);
      check("swap_w3",   32'(cap_word[base+1][3]), 32'h50);
      check("swap_eol",  32'(cap_eol[base+1]), 32'd1);

      // Backpressure: word stays put while 'C' waits upstream
      base = word_cnt;
      i_ready = 1'b0;
      send_str("AB ");
      i_data  = 8'h43;
      i_valid = 1'b1;
      repeat (5) begin
         @(negedge i_clk);
         check("bp_len",   32'(o_len),     32'd2);
         check("bp_ready", 32'(o_ready),   32'd0);
         check("bp_w0",    32'(o_word[0]), 32'h41);
         check("bp_w1",    32'(o_word[1]), 32'h42);
      end
      i_ready = 1'b1;
      @(negedge i_clk);
      check("bp_release_ready", 32'(o_ready), 32'd1);
      check("bp_c_not_taken",   32'(o_len),   32'd0);
      @(negedge i_clk);
      i_valid = 1'b0;
      check("bp_c_len", 32'(o_len),     32'd1);
      check("bp_c_w0",  32'(o_word[0]), 32'h43);
      send(8'h20);
      repeat (2) @(negedge i_clk);
      check("bp_count",  32'(word_cnt - base), 32'd2);
      check("bp_ab_len", 32'(cap_len[base]), 32'd2);
      check("bp_c_word", 32'(cap_word[base+1][0]), 32'h43);
      check("bp_c_wlen", 32'(cap_len[base+1]), 32'd1);

      // Overflow: 40 characters into a 32-character buffer
      base = word_cnt;
      for (int i = 0; i < 40; i++) send(8'h41);
      send(8'h20);
      check("ovf_len", 32'(o_len),      32'd32);
      check("ovf_flag", 32'(o_ovf),     32'd1);
      check("ovf_w31", 32'(o_word[31]), 32'h41);
      send_str("B ");
      repeat (2) @(negedge i_clk);
      check("ovf_count",   32'(word_cnt - base), 32'd2);
      check("ovf_next_ovf", 32'(cap_ovf[base+1]), 32'd0);
      check("ovf_next_len", 32'(cap_len[base+1]), 32'd1);

      // Reset in the middle of a word
      base  = word_cnt;
      send_str("ABC");
      check("mid_len_before", 32'(o_len), 32'd3);
      i_rst_n = 1'b0;
      #1;
      check("mid_rst_len",   32'(o_len),     32'd0);
      check("mid_rst_word0", 32'(o_word[0]), 32'd0);
      check("mid_rst_ready", 32'(o_ready),   32'd1);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      vbase = valid_cycles;
      repeat (3) @(negedge i_clk);
      check("mid_no_valid", 32'(valid_cycles - vbase), 32'd0);
      send_str("D ");
      repeat (2) @(negedge i_clk);
      check("mid_count", 32'(word_cnt - base), 32'd1);
      check("mid_len",   32'(cap_len[base]), 32'd1);
      check("mid_w0",    32'(cap_word[base][0]), 32'h44);

      // Edit characters
      base = word_cnt;
      send(8'h41); send(8'h42); send(8'h08); send(8'h43); send(8'h20);
      repeat (2) @(negedge i_clk);
      check("bs_count", 32'(word_cnt - base), 32'd1);
`ifdef WORD_TOKENIZER_BACKSPACE_EN
      check("bs_len", 32'(cap_len[base]), 32'd2);
      check("bs_w1",  32'(cap_word[base][1]), 32'h43);
      check("bs_w2",  32'(cap_word[base][2]), 32'h00);
`else
      check("bs_len", 32'(cap_len[base]), 32'd4);
      check("bs_w2",  32'(cap_word[base][2]), 32'h08);
      check("bs_w3",  32'(cap_word[base][3]), 32'h43);
`endif
      base = word_cnt;
      send(8'h08); send(8'h20);
      repeat (2) @(negedge i_clk);
`ifdef WORD_TOKENIZER_BACKSPACE_EN
      check("bs_idle_count", 32'(word_cnt - base), 32'd0);
`else
      check("bs_idle_count", 32'(word_cnt - base), 32'd1);
      check("bs_idle_len",   32'(cap_len[base]), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
